mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Sequencing and sharing controller for the single combinational 16x16 array multiplier (`mul` instance, outputs `hi`/`lo`).
- Arbitrates two requesters with round-robin priority, captures the winner's operands, and waits a fixed settle time for the ripple array.
- Registers the 32-bit product and returns it with a per-requester done pulse.
- The `mul` instance is internal to this block; requesters never drive the multiplier directly.

Parameters:
- WAIT_CYCLES, 2, clock cycles allowed for the multiplier to settle after operand capture. Legal range 1..15; 0 is treated as 1. Internal counter is 4 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 request level.
- a0  input  16  requester 0 multiplicand.
- b0  input  16  requester 0 multiplier.
- req1  input  1  requester 1 request level.
- a1  input  16  requester 1 multiplicand.
- b1  input  16  requester 1 multiplier.
- gnt0  output  1  one-cycle pulse: requester 0 operands captured.
- gnt1  output  1  one-cycle pulse: requester 1 operands captured.
- done0  output  1  one-cycle pulse: result for requester 0 valid on hi/lo.
- done1  output  1  one-cycle pulse: result for requester 1 valid on hi/lo.
- hi  output  16  registered product bits 31:16.
- lo  output  16  registered product bits 15:0.
- busy  output  1  high while in CALC.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - gnt0, gnt1, done0, done1, busy = 0.
  - hi, lo = 16'h0000.
  - Operand registers and counter = 0.
  - Priority pointer selects requester 0.
- States: IDLE and CALC.
- IDLE:
  - req0/req1 are sampled on each rising edge.
  - Only one request set: that requester wins.
  - Both set: the requester not granted most recently wins. After reset, requester 0 wins.
  - On a win at edge E0:
    - Capture the winner's a/b into the operand registers.
    - Record the owner.
    - Toggle the priority pointer to the other requester.
    - Load counter = WAIT_CYCLES-1.
    - Go to CALC.
    - Assert gnt<owner> for exactly the cycle after E0.
  - No request: stay in IDLE, all pulses low.
- CALC:
  - busy=1.
  - req inputs are ignored.
  - The counter decrements on each edge.
  - At the edge where counter==0:
    - Latch the multiplier's {hi,lo} into the output registers.
    - Assert done<owner> for one cycle.
    - Return to IDLE.
- Latency: with request sampled at E0, gnt is visible in cycle E0+1 and done in cycle E0+WAIT_CYCLES+1. With WAIT_CYCLES=2: req in cycle 0, gnt in cycle 1, done in cycle 3.
- Throughput: the done cycle is already IDLE, so a request sampled at the end of the done cycle is granted. One product per WAIT_CYCLES+1 cycles.
- Requester rules:
  - Hold req high with stable operands until gnt is seen.
  - Deassert req after gnt. A req still high when the block returns to IDLE is treated as a new request.
  - Operands may change freely after gnt.
- Output hold: hi/lo hold the last result until the next done. They are never altered in IDLE or CALC.
- Product width: full 32 bits, no truncation.
- Default is unsigned: a0=b0=16'hFFFF gives 32'hFFFE0001.
- Reset mid-CALC: the in-flight operation is discarded, no done is issued, and outputs are cleared as at reset.
- Pulse exclusivity: gnt0/gnt1 are never high together, and done0/done1 are never high together.

Optional Feature:
- Macro: MUL_ARB_SIGNED_EN.
- When defined, operands are two's complement:
  - Absolute values are stored in the operand registers.
  - Result sign = a[15] XOR b[15], registered at capture.
  - At latch, the 32-bit product is two's-complement negated when the sign is 1.
  - 16'h8000 magnitude is 32768, which fits unsigned. No overflow is possible.
- When undefined:
  - Operands are passed unmodified and the product is unsigned.
  - No sign register exists.
  - Timing is identical in both builds.

Test Plan:
1. Reset, then req0 with a0=3, b0=5, WAIT_CYCLES=2 -> gnt0 in cycle 1; done0 in cycle 3 with hi=16'h0000, lo=16'h000F; busy high in cycles 1-2.
2. req0 with a0=b0=16'hFFFF, unsigned build -> done0 with hi=16'hFFFE, lo=16'h0001; hi/lo unchanged through the following 5 idle cycles.
3. req0 and req1 asserted in the same cycle after reset, each held until its gnt -> gnt0 first, then after done0 comes gnt1. On a simultaneous request in the next round, gnt0 is granted again, since requester 1 was granted most recently.
4. rst_n pulled low in cycle 2 of an operation with a0=7, b0=9 -> no done pulse, hi=lo=0, busy=0; the next req0 behaves as in scenario 1.
5. MUL_ARB_SIGNED_EN defined with a1=16'hFFFD (-3), b1=5 -> done1 with hi=16'hFFFF, lo=16'hFFF1.
6. MUL_ARB_SIGNED_EN defined with a0=b0=16'h8000 -> hi=16'h4000, lo=16'h0000.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin sharing controller for one combinational 16x16 multiplier.
// Define MUL_ARB_SIGNED_EN for two's-complement operands (sign-magnitude through the array).
module mul_arbiter_mul (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] hi_o,
  output logic [15:0] lo_o
);
  assign {hi_o, lo_o} = {16'h0000, a_i} * {16'h0000, b_i};
endmodule

module mul_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] hi,
  output logic [15:0] lo,
  output logic        busy
);
  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic        prio_q;
  logic        owner_q;
  logic [3:0]  cnt_q;
  logic [15:0] op_a_q;
  logic [15:0] op_b_q;
  logic [15:0] hi_q;
  logic [15:0] lo_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;

  logic        win_any_s;
  logic        win_sel_s;
  logic [15:0] raw_a_s;
  logic [15:0] raw_b_s;
  logic [15:0] cap_a_s;
  logic [15:0] cap_b_s;
  logic        cap_sign_s;
  logic [15:0] mul_hi_s;
  logic [15:0] mul_lo_s;
  logic [31:0] prod_d;

  // Two's-complement magnitude; 16'h8000 maps to 32768, which is still exact.
  function automatic logic [15:0] abs16(input logic [15:0] v);
    abs16 = v[15] ? (~v + 16'd1) : v;
  endfunction

  // Winner selection: prio_q names the requester favoured on a tie.
  always_comb begin
    win_any_s = req0 | req1;
    if (req0 && req1) begin
      win_sel_s = prio_q;
    end else if (req1) begin
      win_sel_s = 1'b1;
    end else begin
      win_sel_s = 1'b0;
    end
    raw_a_s = win_sel_s ? a1 : a0;
    raw_b_s = win_sel_s ? b1 : b0;
`ifdef MUL_ARB_SIGNED_EN
    cap_a_s    = abs16(raw_a_s);
    cap_b_s    = abs16(raw_b_s);
    cap_sign_s = raw_a_s[15] ^ raw_b_s[15];
`else
    cap_a_s    = raw_a_s;
    cap_b_s    = raw_b_s;
    cap_sign_s = 1'b0;
`endif
  end

  mul_arbiter_mul u_mul (
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .hi_o (mul_hi_s),
    .lo_o (mul_lo_s)
  );

`ifdef MUL_ARB_SIGNED_EN
  logic sign_q;

  // Result sign travels with the captured magnitudes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else if (state_q == IDLE && win_any_s) begin
      sign_q <= cap_sign_s;
    end else begin
      sign_q <= sign_q;
    end
  end

  assign prod_d = sign_q ? (~{mul_hi_s, mul_lo_s} + 32'd1) : {mul_hi_s, mul_lo_s};
`else
  assign prod_d = {mul_hi_s, mul_lo_s};
`endif

  // Arbitration FSM with registered grant/done pulses and product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
      op_a_q  <= 16'h0000;
      op_b_q  <= 16'h0000;
      hi_q    <= 16'h0000;
      lo_q    <= 16'h0000;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_any_s) begin
            op_a_q  <= cap_a_s;
            op_b_q  <= cap_b_s;
            owner_q <= win_sel_s;
            prio_q  <= ~win_sel_s;
            cnt_q   <= CNT_LOAD;
            gnt0_q  <= ~win_sel_s;
            gnt1_q  <= win_sel_s;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (cnt_q == 4'd0) begin
            hi_q    <= prod_d[31:16];
            lo_q    <= prod_d[15:0];
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == CALC);
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed + randomized bench for mul_arbiter against a transaction-level model.
module tb_mul_arbiter;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [15:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  int prefer   = 0;
  logic [31:0] last_prod = 32'd0;

  mul_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL_ARB_SIGNED_EN
    ref_prod = {{16{a[15]}}, a} * {{16{b[15]}}, b};
`else
    ref_prod = {16'h0000, a} * {16'h0000, b};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_pulses", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_hold", {hi, lo}, last_prod);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("rst_pulses", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hilo", {hi, lo}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    prefer = 0;
    last_prod = 32'd0;
  endtask

  // One operation: requests already driven for the current cycle.
  task automatic op();
    int w;
    logic [31:0] prod;
    if (req0 && req1) w = prefer;
    else if (req0) w = 0;
    else w = 1;
    prod = (w == 1) ? ref_prod(a1, b1) : ref_prod(a0, b0);
    prefer = 1 - w;
    step();
    chk("gnt", {30'd0, gnt1, gnt0}, (w == 1) ? 32'd2 : 32'd1);
    chk("gnt_done", {30'd0, done1, done0}, 32'd0);
    chk("gnt_busy", {31'd0, busy}, 32'd1);
    chk("gnt_hold", {hi, lo}, last_prod);
    if (w == 1) begin
      req1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom);
    end else begin
      req0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom);
    end
    for (int c = 2; c <= W; c++) begin
      step();
      chk("calc_pulses", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
      chk("calc_busy", {31'd0, busy}, 32'd1);
      chk("calc_hold", {hi, lo}, last_prod);
    end
    step();
    chk("done", {30'd0, done1, done0}, (w == 1) ? 32'd2 : 32'd1);
    chk("done_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("product", {hi, lo}, prod);
    last_prod = prod;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 16'h0000; b0 = 16'h0000; a1 = 16'h0000; b1 = 16'h0000;
    do_reset();
    idle(1);

    req0 = 1'b1; a0 = 16'd3; b0 = 16'd5;
    op();
    chk("s1_value", {hi, lo}, 32'h0000_000F);

    req0 = 1'b1; a0 = 16'hFFFF; b0 = 16'hFFFF;
    op();
`ifndef MUL_ARB_SIGNED_EN
    chk("s2_value", {hi, lo}, 32'hFFFE_0001);
`endif
    idle(5);

    // Reset during CALC discards the operation.
    req0 = 1'b1; a0 = 16'd7; b0 = 16'd9;
    step();
    chk("s4_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("s4_hilo", {hi, lo}, 32'd0);
    chk("s4_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_no_done", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
    end
    rst_n = 1'b1;
    prefer = 0;
    last_prod = 32'd0;
    req0 = 1'b1; a0 = 16'd3; b0 = 16'd5;
    op();
    chk("s4_value", {hi, lo}, 32'h0000_000F);

    do_reset();
    req0 = 1'b1; a0 = 16'd100; b0 = 16'd200;
    req1 = 1'b1; a1 = 16'd300; b1 = 16'd400;
    op();
    chk("s3_first_owner", {31'd0, req1}, 32'd1);
    op();
    chk("s3_second", {hi, lo}, 32'd120000);
    idle(1);
    req0 = 1'b1; a0 = 16'd11; b0 = 16'd13;
    req1 = 1'b1; a1 = 16'd17; b1 = 16'd19;
    op();
    chk("s3_round2_r0", {hi, lo}, 32'd143);
    op();

`ifdef MUL_ARB_SIGNED_EN
    idle(1);
    req1 = 1'b1; a1 = 16'hFFFD; b1 = 16'd5;
    op();
    chk("s5_value", {hi, lo}, 32'hFFFF_FFF1);
    req0 = 1'b1; a0 = 16'h8000; b0 = 16'h8000;
    op();
    chk("s6_value", {hi, lo}, 32'h4000_0000);
`endif

    for (int it = 0; it < 30; it++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      req0 = pat[0]; req1 = pat[1];
      a0 = 16'($urandom); b0 = 16'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom);
      if (it % 7 == 0) begin
        a0 = 16'hFFFF; b1 = 16'h8000;
      end
      op();
      if (req0 || req1) op();
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
